// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the Hack PC / instruction-fetch stage
// Contents: fetch FSM state encoding, instruction width, default reset vector.
package pc_fetch_pkg;
    typedef enum logic {S_WAIT = 1'b0, S_VALID = 1'b1} state_t;
    localparam int INSTR_W = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: CPU-side request/handshake and ROM-side bus of the fetch stage
// Signals: CLR/LOAD/INC/IN requests, INSTR/INSTR_VALID/INSTR_READY handshake,
//          OUT current PC, ROM_ADDR/ROM_DATA instruction ROM bus,
//          RETIRED accept count (only with PC_FETCH_RETIRE_CNT_EN).
// Modports: master = CPU control + ROM side, slave = pc_fetch.
interface pc_fetch_if
    import pc_fetch_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic               CLR;
    logic               LOAD;
    logic               INC;
    logic [WIDTH-1:0]   IN;
    logic [WIDTH-1:0]   ROM_ADDR;
    logic [INSTR_W-1:0] ROM_DATA;
    logic [INSTR_W-1:0] INSTR;
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic [WIDTH-1:0]   OUT;
`ifdef PC_FETCH_RETIRE_CNT_EN
    logic [31:0]        RETIRED;
    modport master (output CLR, LOAD, INC, IN, ROM_DATA, INSTR_READY,
                    input ROM_ADDR, INSTR, INSTR_VALID, OUT, RETIRED);
    modport slave  (input CLR, LOAD, INC, IN, ROM_DATA, INSTR_READY,
                    output ROM_ADDR, INSTR, INSTR_VALID, OUT, RETIRED);
`else
    modport master (output CLR, LOAD, INC, IN, ROM_DATA, INSTR_READY,
                    input ROM_ADDR, INSTR, INSTR_VALID, OUT);
    modport slave  (input CLR, LOAD, INC, IN, ROM_DATA, INSTR_READY,
                    output ROM_ADDR, INSTR, INSTR_VALID, OUT);
`endif
endinterface

// File: rtl/pc_reg.sv
// pc_reg: WIDTH-bit program counter with CLR > LOAD > INC priority
// Ports: clk, rst (async, active-high), clr_i, load_i, inc_i update requests,
//        in_i jump target, pc_o current PC.
module pc_reg #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] pc_o
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             en;
    always_comb begin
        en   = clr_i | load_i | inc_i;
        pc_d = clr_i ? RESET_VECTOR : load_i ? in_i : inc_i ? pc_q + WIDTH'(1) : pc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_VECTOR;
        else if (en)
            pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: Hack program counter and instruction-fetch stage with valid/ready output
// Ports: CLK, RST (async, active-high), bus (pc_fetch_if.slave): CLR/LOAD/INC/IN
//        requests, ROM_ADDR/ROM_DATA ROM bus, INSTR/INSTR_VALID/INSTR_READY
//        handshake, OUT current PC.
// Option: define PC_FETCH_RETIRE_CNT_EN to add the 32-bit RETIRED accept counter.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic     CLK,
    input  logic     RST,
    pc_fetch_if.slave bus
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               boot_q;
    logic               accept;
    logic [WIDTH-1:0]   pc;

    assign accept = (state_q == S_VALID) & bus.INSTR_READY;

    pc_reg #(.WIDTH(WIDTH), .RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk    (CLK),
        .rst    (RST),
        .clr_i  (bus.CLR),
        .load_i (accept & bus.LOAD),
        .inc_i  (accept & bus.INC),
        .in_i   (bus.IN),
        .pc_o   (pc)
    );

    // boot_q marks the first edge after reset release, which only launches
    // the ROM read of the reset vector; later waits capture on their first edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_WAIT;
            instr_q <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            boot_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = bus.CLR ? S_WAIT :
                  (state_q == S_WAIT) ? (boot_q ? S_WAIT : S_VALID) :
                  (accept ? S_WAIT : S_VALID);
        instr_d = (state_q == S_WAIT && !boot_q && !bus.CLR) ? bus.ROM_DATA : instr_q;
    end

    always_comb begin
        bus.ROM_ADDR    = pc;
        bus.OUT         = pc;
        bus.INSTR       = instr_q;
        bus.INSTR_VALID = (state_q == S_VALID);
    end

`ifdef PC_FETCH_RETIRE_CNT_EN
    logic [31:0] retired_q;
    // an accept coinciding with CLR is discarded, so it is not counted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            retired_q <= '0;
        else if (bus.CLR)
            retired_q <= '0;
        else if (accept)
            retired_q <= retired_q + 32'd1;
    end
    assign bus.RETIRED = retired_q;
`endif
endmodule
